// File: rtl/view_data_disp.sv
// Front-panel debug viewer: debounces KEY[3:1], steps between memory/register/PSW views
// and shows the selected 16-bit value on four 7-segment digits and on LEDR.
module view_data_disp #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] mem_data,
  input  logic [15:0] reg_data,
  input  logic [15:0] psw_data,
  input  logic [15:0] addr,
  input  logic        view_key,
  input  logic [1:0]  mem_mode,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [5:0]  LEDG,
  output logic [15:0] LEDR
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {V_MEM, V_REG, V_PSW} view_e;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Key bit order throughout: [0]=KEY1 next view, [1]=KEY2 memory view, [2]=KEY3 byte toggle
  logic [2:0]       raw_keys;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       deb_q, deb_d;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  view_e       view_q, view_d;
  logic        byte_q, byte_d;

  logic [15:0] value;
  logic        blank_hi;
  logic [5:0]  ledg_d;
  logic        addr_unused;

  assign raw_keys    = {view_key, mem_mode};
  assign addr_unused = ^addr[2:1];

  always_comb begin
    deb_d = deb_q;
    press = '0;
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[k] = sync2_q[k];
          press[k] = ~sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    view_d = view_q;
    byte_d = byte_q ^ press[2];
    if (press[1]) begin
      view_d = V_MEM;
    end else if (press[0]) begin
      case (view_q)
        V_MEM:   view_d = V_REG;
        V_REG:   view_d = V_PSW;
        default: view_d = V_MEM;
      endcase
    end
  end

  always_comb begin
    value    = mem_data;
    blank_hi = 1'b0;
    case (view_q)
      V_REG:   value = reg_data;
      V_PSW:   value = psw_data;
      default: begin
        if (byte_q) begin
          value    = {8'h00, mem_data[7:0]};
          blank_hi = 1'b1;
        end
      end
    endcase
    ledg_d = {(view_q == V_REG) && (addr[15:3] != 13'd0),
              (view_q == V_MEM) && !byte_q && addr[0],
              byte_q,
              view_q == V_PSW,
              view_q == V_REG,
              view_q == V_MEM};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
      view_q  <= V_MEM;
      byte_q  <= 1'b0;
      HEX0    <= SEG_BLANK;
      HEX1    <= SEG_BLANK;
      HEX2    <= SEG_BLANK;
      HEX3    <= SEG_BLANK;
      LEDG    <= '0;
      LEDR    <= '0;
    end else begin
      sync1_q <= raw_keys;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
      view_q  <= view_d;
      byte_q  <= byte_d;
      HEX0    <= seg7(value[3:0]);
      HEX1    <= seg7(value[7:4]);
      HEX2    <= blank_hi ? SEG_BLANK : seg7(value[11:8]);
      HEX3    <= blank_hi ? SEG_BLANK : seg7(value[15:12]);
      LEDG    <= ledg_d;
      LEDR    <= value;
    end
  end

endmodule

// File: tb/tb_view_data_disp.sv
// Directed bench for view_data_disp with a short debounce window; all expectations hand-derived.
module tb_view_data_disp;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] mem_data, reg_data, psw_data, addr;
  logic        view_key;
  logic [1:0]  mem_mode;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [5:0]  LEDG;
  logic [15:0] LEDR;

  int errs   = 0;
  int checks = 0;

  view_data_disp #(.DEBOUNCE_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .mem_data(mem_data), .reg_data(reg_data), .psw_data(psw_data), .addr(addr),
    .view_key(view_key), .mem_mode(mem_mode),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .LEDG(LEDG), .LEDR(LEDR)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hex(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                         input logic [6:0] h1, input logic [6:0] h0);
    chk({tag, ".HEX3"}, {25'd0, HEX3}, {25'd0, h3});
    chk({tag, ".HEX2"}, {25'd0, HEX2}, {25'd0, h2});
    chk({tag, ".HEX1"}, {25'd0, HEX1}, {25'd0, h1});
    chk({tag, ".HEX0"}, {25'd0, HEX0}, {25'd0, h0});
  endtask

  // k: [0]=KEY1, [1]=KEY2, [2]=KEY3; held low for 'lo' cycles, then released and settled
  task automatic press(input logic [2:0] k, input int lo);
    view_key = ~k[2];
    mem_mode = ~k[1:0];
    repeat (lo) @(negedge Clock);
    view_key = 1'b1;
    mem_mode = 2'b11;
    repeat (12) @(negedge Clock);
  endtask

  initial begin
    Reset    = 1'b1;
    mem_data = 16'h1234;
    reg_data = 16'h5678;
    psw_data = 16'hABC8;
    addr     = 16'h0000;
    view_key = 1'b1;
    mem_mode = 2'b11;

    repeat (2) @(negedge Clock);
    chk_hex("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("reset.LEDG", {26'd0, LEDG}, 32'h0);
    chk("reset.LEDR", {16'd0, LEDR}, 32'h0);

    Reset = 1'b0;
    @(negedge Clock);
    chk_hex("mem1234", 7'h79, 7'h24, 7'h30, 7'h19);
    chk("mem1234.LEDR", {16'd0, LEDR}, 32'h1234);
    chk("mem1234.LEDG", {26'd0, LEDG}, 32'h01);

    press(3'b001, 10);
    chk_hex("reg5678", 7'h12, 7'h02, 7'h78, 7'h00);
    chk("reg5678.LEDG", {26'd0, LEDG}, 32'h02);
    chk("reg5678.LEDR", {16'd0, LEDR}, 32'h5678);

    press(3'b001, 10);
    chk_hex("pswABC8", 7'h08, 7'h03, 7'h46, 7'h00);
    chk("pswABC8.LEDG", {26'd0, LEDG}, 32'h04);

    press(3'b001, 10);
    chk("wrap.LEDG", {26'd0, LEDG}, 32'h01);
    chk("wrap.LEDR", {16'd0, LEDR}, 32'h1234);

    mem_data = 16'hBEEF;
    press(3'b100, 10);
    chk_hex("byteEF", 7'h7F, 7'h7F, 7'h06, 7'h0E);
    chk("byteEF.LEDR", {16'd0, LEDR}, 32'h00EF);
    chk("byteEF.LEDG", {26'd0, LEDG}, 32'h09);

    // byte_mode is sticky across views but only changes what MEM shows
    press(3'b001, 10);
    chk("byteREG.LEDR", {16'd0, LEDR}, 32'h5678);
    chk("byteREG.LEDG", {26'd0, LEDG}, 32'h0A);
    press(3'b010, 10);
    press(3'b100, 10);
    chk("word.LEDR", {16'd0, LEDR}, 32'hBEEF);
    chk_hex("wordBEEF", 7'h03, 7'h06, 7'h06, 7'h0E);

    press(3'b001, 2);
    chk("glitch.LEDG", {26'd0, LEDG}, 32'h01);

    press(3'b001, 10);
    chk("toREG.LEDG", {26'd0, LEDG}, 32'h02);
    press(3'b011, 10);
    chk("both.LEDG", {26'd0, LEDG}, 32'h01);

    press(3'b001, 10);
    addr = 16'h0009;
    @(negedge Clock);
    chk("badreg.LEDG", {26'd0, LEDG}, 32'h22);
    addr = 16'h0007;
    @(negedge Clock);
    chk("goodreg.LEDG", {26'd0, LEDG}, 32'h02);
    press(3'b010, 10);
    addr = 16'h0003;
    @(negedge Clock);
    chk("oddaddr.LEDG", {26'd0, LEDG}, 32'h11);

    mem_mode = 2'b10;
    repeat (4) @(negedge Clock);
    Reset    = 1'b1;
    mem_mode = 2'b11;
    @(negedge Clock);
    chk_hex("midreset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("midreset.LEDG", {26'd0, LEDG}, 32'h0);
    Reset = 1'b0;
    repeat (12) @(negedge Clock);
    chk("postreset.LEDG", {26'd0, LEDG}, 32'h11);
    chk("postreset.LEDR", {16'd0, LEDR}, 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
